// File: rtl/count_display_driver_if.sv
// Link between the step counter and the display driver: the binary count in,
// and the BCD result with its status flags out.
interface count_display_driver_if;
    logic [7:0]  count;
    logic [11:0] bcd;
    logic        valid;
    logic        busy;

    modport master (output count, input bcd, input valid, input busy);
    modport slave  (input count, output bcd, output valid, output busy);
endinterface

// File: rtl/count_display_driver.sv
// Converts the 8-bit count to BCD with a bit-serial double-dabble engine and
// scans the three digits onto a common-anode 7-segment display with zero blanking.
module count_display_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    count_display_driver_if.slave bus,
    output logic [2:0]            an,
    output logic [6:0]            seg
);
    localparam int         PW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state, state_next;
    logic [19:0] sr, sr_next, sr_adj, sr_shift;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  last_val, last_val_next;
    logic        pending, pending_next;
    logic [11:0] bcd_q, bcd_next;
    logic        valid_q, valid_next;
    logic        busy_q, busy_next;

    logic [PW-1:0] prescaler;
    logic [1:0]    idx, idx_next;
    logic          last_tick;
    logic [3:0]    digit;
    logic          blank;
    logic [6:0]    lit;
    logic [6:0]    seg_next;

    // sr holds {hundreds, tens, ones, binary}; nibbles >= 5 are corrected before each shift
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < 3; i++) begin
            if (sr[8 + 4*i +: 4] >= 4'd5)
                sr_adj[8 + 4*i +: 4] = sr[8 + 4*i +: 4] + 4'd3;
        end
        sr_shift = {sr_adj[18:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sr       <= '0;
            bit_cnt  <= '0;
            last_val <= '0;
            pending  <= 1'b1;
            bcd_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_next;
            sr       <= sr_next;
            bit_cnt  <= bit_cnt_next;
            last_val <= last_val_next;
            pending  <= pending_next;
            bcd_q    <= bcd_next;
            valid_q  <= valid_next;
            busy_q   <= busy_next;
        end
    end

    always_comb begin
        state_next    = state;
        sr_next       = sr;
        bit_cnt_next  = bit_cnt;
        last_val_next = last_val;
        pending_next  = pending;
        bcd_next      = bcd_q;
        valid_next    = valid_q;
        busy_next     = busy_q;
        case (state)
            IDLE: begin
                if (pending || (bus.count != last_val)) begin
                    sr_next       = {12'd0, bus.count};
                    last_val_next = bus.count;
                    pending_next  = 1'b0;
                    bit_cnt_next  = 3'd0;
                    busy_next     = 1'b1;
                    state_next    = SHIFT;
                end
            end
            SHIFT: begin
                sr_next      = sr_shift;
                bit_cnt_next = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    bcd_next   = sr_shift[19:8];
                    valid_next = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.bcd   = bcd_q;
    assign bus.valid = valid_q;
    assign bus.busy  = busy_q;

    assign last_tick = (prescaler == PW'(SCAN_DIV - 1));

    always_comb begin
        idx_next = idx;
        if (last_tick)
            idx_next = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end

    // an and seg are both derived from the upcoming digit index so they switch together
    always_comb begin
        case (idx_next)
            2'd1:    digit = bcd_q[7:4];
            2'd2:    digit = bcd_q[11:8];
            default: digit = bcd_q[3:0];
        endcase
        blank = !valid_q
              || ((idx_next == 2'd2) && (bcd_q[11:8] == 4'd0))
              || ((idx_next == 2'd1) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0));
        case (digit)
            4'd0:    lit = 7'h3F;
            4'd1:    lit = 7'h06;
            4'd2:    lit = 7'h5B;
            4'd3:    lit = 7'h4F;
            4'd4:    lit = 7'h66;
            4'd5:    lit = 7'h6D;
            4'd6:    lit = 7'h7D;
            4'd7:    lit = 7'h07;
            4'd8:    lit = 7'h7F;
            4'd9:    lit = 7'h6F;
            default: lit = 7'h00;
        endcase
        if (blank)
            seg_next = SEG_OFF;
        else
            seg_next = SEG_ACTIVE_LOW ? ~lit : lit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= 2'd0;
            an        <= 3'b110;
            seg       <= SEG_OFF;
        end else begin
            prescaler <= last_tick ? '0 : prescaler + 1'b1;
            idx       <= idx_next;
            an        <= ~(3'b001 << idx_next);
            seg       <= seg_next;
        end
    end
endmodule

// File: tb/tb_count_display_driver.sv
// Randomized scoreboard bench for count_display_driver: an integer-arithmetic model
// predicts conversions and the digit scan, a negedge monitor compares.
module tb_count_display_driver;
    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] an;
    logic [6:0] seg;

    count_display_driver_if bus();

    count_display_driver #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .an  (an),
        .seg (seg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: the displayed value is kept as a plain integer
    int         m_val, m_last, m_left, m_k;
    bit         m_valid, m_pending, m_ready = 1'b0;
    logic [2:0] m_an;
    logic [6:0] m_seg;
    int         exp_q[$];

    logic [6:0] lit_tbl [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [2:0] an_tbl  [3]  = '{3'b110, 3'b101, 3'b011};

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'(v / 100);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [6:0] seg_for(input int v, input bit vld, input int pos);
        int  h, t, o, d;
        bit  blank;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        d = (pos == 2) ? h : (pos == 1) ? t : o;
        blank = !vld || (pos == 2 && h == 0) || (pos == 1 && h == 0 && t == 0);
        return blank ? 7'h7F : ~lit_tbl[d];
    endfunction

    task automatic compareValue(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, want);
        end
    endtask

    // Reference model: one step per clock edge, computed from the conversion/scan rules
    always @(posedge clk) begin
        if (rst) begin
            m_val = 0; m_last = 0; m_left = 0; m_k = 0;
            m_valid = 1'b0; m_pending = 1'b1; m_ready = 1'b1;
            m_an = 3'b110; m_seg = 7'h7F;
            exp_q.delete();
        end else if (m_ready) begin
            m_k++;
            m_an  = an_tbl[(m_k / SD) % 3];
            m_seg = seg_for(m_val, m_valid, (m_k / SD) % 3);
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_val   = m_last;
                    m_valid = 1'b1;
                end
            end else if (m_pending || (int'(bus.count) != m_last)) begin
                m_last    = int'(bus.count);
                m_pending = 1'b0;
                m_left    = 8;
                exp_q.push_back(m_last);
            end
        end
    end

    bit prev_busy = 1'b0;
    int busy_len  = 0;

    task automatic checkOutput();
        int exp_v;
        compareValue("busy",  32'(bus.busy),  32'(m_left > 0));
        compareValue("valid", 32'(bus.valid), 32'(m_valid));
        compareValue("bcd",   32'(bus.bcd),   32'(to_bcd(m_val)));
        compareValue("an",    32'(an),        32'(m_an));
        compareValue("seg",   32'(seg),       32'(m_seg));
        if (prev_busy && !bus.busy && bus.valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_result at %0t: got=%0h expected=none queued", $time, bus.bcd);
            end else begin
                exp_v = exp_q.pop_front();
                compareValue("sb_result", 32'(bus.bcd), 32'(to_bcd(exp_v)));
            end
            compareValue("busy_cycles", 32'(busy_len), 32'd8);
            busy_len = 0;
        end
        if (bus.busy) busy_len++;
        prev_busy = bus.busy;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else if (m_ready) begin
            checkOutput();
        end
    end

    task automatic applyStimulus(input int v, input int cycles);
        bus.count = 8'(v);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.count = 8'd0;
        @(posedge clk);
        #1;
        doReset(2);
        $display("[TB] directed sequence");
        applyStimulus(0, 14);
        applyStimulus(255, 40);
        applyStimulus(105, 14);
        applyStimulus(7, 14);
        applyStimulus(12, 3);
        applyStimulus(200, 30);
        applyStimulus(99, 4);
        doReset(1);
        applyStimulus(99, 16);
        $display("[TB] random sequence");
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 24) == 0)
                doReset($urandom_range(1, 2));
            if ($urandom_range(0, 5) == 0)
                applyStimulus(int'(bus.count), $urandom_range(1, 14));
            else
                applyStimulus($urandom_range(0, 255), $urandom_range(1, 14));
        end
        applyStimulus(int'(bus.count), 24);
        compareValue("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
